// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the decimal arithmetic datapath.
// Imported by the serial BCD subtractor and its per-digit slice.
package bcd_pkg;

  localparam int DIGIT_W   = 4;
  localparam int BCD_MAX   = 9;
  localparam int BCD_RADIX = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of subtraction with borrow: d = a - b - bin, wrapped into 0..9.
// Also flags either input digit outside the BCD range.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout,
  output logic               bad
);

  logic [5:0] w_t;
  logic [5:0] w_adj;

  // Six-bit two's-complement difference; bit 5 set means the digit went negative.
  assign w_t   = {2'b00, a} - {2'b00, b} - {5'b00000, bin};
  assign w_adj = w_t + 6'(BCD_RADIX);
  assign bout  = w_t[5];
  assign d     = bout ? w_adj[DIGIT_W-1:0] : w_t[DIGIT_W-1:0];
  assign bad   = (a > 4'(BCD_MAX)) || (b > 4'(BCD_MAX));

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor: Diff = A - B, one digit per clock, LSD first.
// Ten's-complement result with borrow flag; start/busy/done handshake.
module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DIGIT_W*NDIGITS-1:0] A,
  input  logic [DIGIT_W*NDIGITS-1:0] B,
  output logic [DIGIT_W*NDIGITS-1:0] Diff,
  output logic                       Borrow,
  output logic                       Invalid,
  output logic                       busy,
  output logic                       done
);

  localparam int W     = DIGIT_W * NDIGITS;
  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NDIGITS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_work;
  logic             r_br;
  logic             r_inv;

  logic [DIGIT_W-1:0] w_d;
  logic               w_bout;
  logic               w_bad;

  bcd_digit_sub u_digit (
    .a    (r_a[DIGIT_W-1:0]),
    .b    (r_b[DIGIT_W-1:0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout),
    .bad  (w_bad)
  );

  // NOTE: every state flop uses <= so all updates see pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_br    <= 1'b0;
      r_inv   <= 1'b0;
      Diff    <= '0;
      Borrow  <= 1'b0;
      Invalid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_br    <= 1'b0;
            r_inv   <= 1'b0;
            r_cnt   <= '0;
            r_work  <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          busy   <= 1'b1;
          r_a    <= r_a >> DIGIT_W;
          r_b    <= r_b >> DIGIT_W;
          r_work <= (r_work >> DIGIT_W) | (W'(w_d) << (W - DIGIT_W));
          r_br   <= w_bout;
          // Every captured digit passes through the slice once, so OR-ing covers all of A and B.
          r_inv  <= r_inv | w_bad;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST_DIGIT) r_state <= DONE;
        end
        DONE: begin
          done    <= 1'b1;
          Invalid <= r_inv;
          Diff    <= r_inv ? '0 : r_work;
          Borrow  <= r_inv ? 1'b0 : r_br;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Directed table plus multi-cycle corner sequences and a random run against a decimal model.
`timescale 1ns/1ps
module tb_bcd_sub_serial;

  localparam int N = 2;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A, B;
  logic [W-1:0] Diff;
  logic         Borrow, Invalid, busy, done;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
    logic       inv;
    string      name;
  } vec_t;

  vec_t vecs[8];

  bcd_sub_serial #(.NDIGITS(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .Diff    (Diff),
    .Borrow  (Borrow),
    .Invalid (Invalid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] d, output logic br, output logic inv);
    int ai, bi, df;
    inv = (a[3:0] > 9) || (a[7:4] > 9) || (b[3:0] > 9) || (b[7:4] > 9);
    d = 8'h00;
    br = 1'b0;
    if (!inv) begin
      ai = int'(a[7:4]) * 10 + int'(a[3:0]);
      bi = int'(b[7:4]) * 10 + int'(b[3:0]);
      df = ai - bi;
      if (df < 0) begin
        df = df + 100;
        br = 1'b1;
      end
      d = {4'(df / 10), 4'(df % 10)};
    end
  endfunction

  // One full operation: capture at edge T, observe cycles T..T+4 at the falling edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                        input logic ebr, input logic einv, input string nm);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = ~a;
    B = 8'h00;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check({nm, " busy"}, 32'(busy), 32'((k >= 1) && (k <= 3)));
      check({nm, " done"}, 32'(done), 32'(k == 3));
      if (k >= 3) begin
        check({nm, " diff"}, 32'(Diff), 32'(ed));
        check({nm, " borrow"}, 32'(Borrow), 32'(ebr));
        check({nm, " invalid"}, 32'(Invalid), 32'(einv));
      end
    end
  endtask

  initial begin
    logic [7:0] ra, rb, ed;
    logic       ebr, einv;
    int         pulses;

    vecs[0] = '{8'h62, 8'h59, 8'h03, 1'b0, 1'b0, "62-59"};
    vecs[1] = '{8'h43, 8'h59, 8'h84, 1'b1, 1'b0, "43-59"};
    vecs[2] = '{8'h00, 8'h01, 8'h99, 1'b1, 1'b0, "00-01"};
    vecs[3] = '{8'h29, 8'h6C, 8'h00, 1'b0, 1'b1, "29-6C"};
    vecs[4] = '{8'h99, 8'h00, 8'h99, 1'b0, 1'b0, "99-00"};
    vecs[5] = '{8'h50, 8'h50, 8'h00, 1'b0, 1'b0, "50-50"};
    vecs[6] = '{8'h10, 8'h01, 8'h09, 1'b0, 1'b0, "10-01"};
    vecs[7] = '{8'hA0, 8'h05, 8'h00, 1'b0, 1'b1, "A0-05"};

    rst_n = 1'b0;
    start = 1'b1;
    A = 8'h62;
    B = 8'h59;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(Diff), 32'd0);
    check("reset borrow", 32'(Borrow), 32'd0);
    check("reset invalid", 32'(Invalid), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].inv, vecs[i].name);

    // Start re-pulsed during RUN with other operands must be ignored.
    @(negedge clk);
    A = 8'h62;
    B = 8'h59;
    start = 1'b1;
    @(posedge clk);
    #1;
    A = 8'h11;
    B = 8'h11;
    @(posedge clk);
    #1;
    start = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("ignore done", 32'(done), 32'(k == 3));
      if (done) pulses++;
      if (k >= 3) check("ignore diff", 32'(Diff), 32'h03);
    end
    check("ignore pulses", 32'(pulses), 32'd1);

    // Reset two edges into an operation aborts it with no done pulse.
    run_op(8'h43, 8'h59, 8'h84, 1'b1, 1'b0, "pre-reset");
    @(negedge clk);
    A = 8'h62;
    B = 8'h59;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort diff", 32'(Diff), 32'd0);
    check("abort borrow", 32'(Borrow), 32'd0);
    check("abort invalid", 32'(Invalid), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort no done", 32'(done), 32'd0);
    end

    // Start held high: second capture on the first IDLE cycle after DONE.
    @(negedge clk);
    A = 8'h62;
    B = 8'h59;
    start = 1'b1;
    @(posedge clk);
    #1;
    A = 8'h43;
    B = 8'h59;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      check("b2b done", 32'(done), 32'((k == 3) || (k == 7)));
      if (k == 3) begin
        check("b2b diff1", 32'(Diff), 32'h03);
        check("b2b borrow1", 32'(Borrow), 32'd0);
      end
      if (k == 7) begin
        check("b2b diff2", 32'(Diff), 32'h84);
        check("b2b borrow2", 32'(Borrow), 32'd1);
      end
      if (k == 4) begin
        start = 1'b0;
        A = 8'h00;
        B = 8'h00;
      end
    end

    for (int i = 0; i < 1000; i++) begin
      ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      model(ra, rb, ed, ebr, einv);
      run_op(ra, rb, ed, ebr, einv, "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
